// File: rtl/uart_frame_ctrl_pkg.sv
// Shared constants, error codes and state encoding for the UART frame controller.
// The state encoding is shared with uart_rx so both can be decoded from one table.
package uart_frame_ctrl_pkg;

    localparam int CLK_HZ = 12_000_000;
    localparam int BAUD   = 9600;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CSUM    = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    // Pointer width that stays legal for a single-entry buffer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_ctrl_inter_byte_timer.sv
// Inter-byte watchdog: counts while run is high, flags expiry on the clock that
// would bring the count to TIMEOUT_CLKS-1 without an intervening clear.
module inter_byte_timer #(
    parameter int TIMEOUT_CLKS = 12000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign expired = run && (count_reg == CNT_W'(TIMEOUT_CLKS - 2));

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame controller above uart_rx: hunts for SYNC, collects LEN/payload/CSUM into a
// local buffer and streams the payload out only after the checksum matches.
module uart_frame_ctrl
    import uart_frame_ctrl_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CLKS = CLK_HZ / 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       byte_available,
    output logic       rx_enable,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int         PTR_W     = ptr_width(MAX_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t state_reg;
    state_t state_next;

    logic             byte_available_q_reg;
    logic             strobe;
    logic [7:0]       len_reg;
    logic [7:0]       sum_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [7:0]       buf_mem [MAX_LEN];

    logic             frame_err_reg;
    logic [1:0]       err_code_reg;
    logic             rx_enable_reg;

    logic             err_fire;
    logic [1:0]       err_sel;
    logic             len_ok;
    logic             csum_ok;
    logic             wr_last;
    logic             rd_last;
    logic             timer_clear;
    logic             timer_run;
    logic             timer_expired;

    // One strobe per byte no matter how long uart_rx holds its level.
    assign strobe  = byte_available && !byte_available_q_reg;
    assign len_ok  = (rx_byte != 8'd0) && (rx_byte <= MAX_LEN_B);
    assign csum_ok = (rx_byte == sum_reg);
    assign wr_last = (8'(wr_ptr_reg) == (len_reg - 8'd1));
    assign rd_last = (8'(rd_ptr_reg) == (len_reg - 8'd1));

    assign timer_run   = (state_reg == S_LEN) || (state_reg == S_PAYLOAD) ||
                         (state_reg == S_CSUM);
    assign timer_clear = strobe || (state_next != state_reg);

    inter_byte_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .run     (timer_run),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    // A strobe is always checked before expiry, so a byte arriving on the
    // expiry cycle is processed normally.
    always_comb begin
        state_next = state_reg;
        err_fire   = 1'b0;
        err_sel    = ERR_NONE;
        case (state_reg)
            S_HUNT: begin
                if (strobe && (rx_byte == SYNC_BYTE)) begin
                    state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (strobe) begin
                    if (len_ok) begin
                        state_next = S_PAYLOAD;
                    end else begin
                        state_next = S_HUNT;
                        err_fire   = 1'b1;
                        err_sel    = ERR_LEN;
                    end
                end else if (timer_expired) begin
                    state_next = S_HUNT;
                    err_fire   = 1'b1;
                    err_sel    = ERR_TIMEOUT;
                end
            end
            S_PAYLOAD: begin
                if (strobe) begin
                    if (wr_last) begin
                        state_next = S_CSUM;
                    end
                end else if (timer_expired) begin
                    state_next = S_HUNT;
                    err_fire   = 1'b1;
                    err_sel    = ERR_TIMEOUT;
                end
            end
            S_CSUM: begin
                if (strobe) begin
                    if (csum_ok) begin
                        state_next = S_DRAIN;
                    end else begin
                        state_next = S_HUNT;
                        err_fire   = 1'b1;
                        err_sel    = ERR_CSUM;
                    end
                end else if (timer_expired) begin
                    state_next = S_HUNT;
                    err_fire   = 1'b1;
                    err_sel    = ERR_TIMEOUT;
                end
            end
            S_DRAIN: begin
                if (out_ready && rd_last) begin
                    state_next = S_HUNT;
                end
            end
            default: begin
                state_next = S_HUNT;
            end
        endcase
    end

    always_comb begin
        out_valid = (state_reg == S_DRAIN);
        out_last  = (state_reg == S_DRAIN) && rd_last;
        busy      = (state_reg != S_HUNT);
        out_data  = buf_mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_available_q_reg <= 1'b0;
            frame_err_reg        <= 1'b0;
            err_code_reg         <= ERR_NONE;
            rx_enable_reg        <= 1'b0;
        end else begin
            byte_available_q_reg <= byte_available;
            frame_err_reg        <= err_fire;
            rx_enable_reg        <= (state_next != S_DRAIN);
            if (err_fire) begin
                err_code_reg <= err_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg    <= 8'd0;
            sum_reg    <= 8'd0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            case (state_reg)
                S_LEN: begin
                    if (strobe && len_ok) begin
                        len_reg    <= rx_byte;
                        sum_reg    <= rx_byte;
                        wr_ptr_reg <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (strobe) begin
                        sum_reg    <= sum_reg + rx_byte;
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                end
                S_CSUM: begin
                    if (strobe && csum_ok) begin
                        rd_ptr_reg <= '0;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Payload storage carries no reset; only bytes below len_reg are ever read.
    always_ff @(posedge clk) begin
        if ((state_reg == S_PAYLOAD) && strobe) begin
            buf_mem[wr_ptr_reg] <= rx_byte;
        end
    end

    assign frame_err = frame_err_reg;
    assign err_code  = err_code_reg;
    assign rx_enable = rx_enable_reg;

endmodule
